// File: rtl/mini_risc_ctrl_pkg.sv
// Shared encodings and the per-state control decode for the mini-RISC multi-cycle controller.
package mini_risc_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned BR_OP_W  = 5;
  localparam int unsigned WAIT_W   = 4;

  localparam logic [OP_W-1:0] OP_ALU  = 6'h00;
  localparam logic [OP_W-1:0] OP_ALUI = 6'h01;
  localparam logic [OP_W-1:0] OP_LW   = 6'h02;
  localparam logic [OP_W-1:0] OP_SW   = 6'h03;
  localparam logic [OP_W-1:0] OP_BR   = 6'h04;
  localparam logic [OP_W-1:0] OP_BL   = 6'h05;
  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] RW_NONE = 2'd0;
  localparam logic [1:0] RW_RS   = 2'd1;
  localparam logic [1:0] RW_LINK = 2'd2;

  localparam logic [1:0] WB_LINK = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_ALU  = 2'd2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;

  typedef struct packed {
    logic                pc_write;
    logic                ir_write;
    logic [1:0]          reg_write;
    logic                imm_mux_ctrl;
    logic                alu_mux_ctrl;
    logic [ALU_OP_W-1:0] alu_op;
    logic                dmem_enable;
    logic                dmem_write_enable;
    logic [1:0]          reg_write_mux_ctrl;
    logic [BR_OP_W-1:0]  br_op;
    logic                halted;
    logic                illegal_op;
  } ctrl_t;

  // Control word for a given state and latched instruction fields.
  function automatic ctrl_t ctrl_decode(input state_t st, input logic [OP_W-1:0] op,
                                        input logic [FUNC_W-1:0] fn, input logic mem_last);
    ctrl_t c;
    c = '0;
    // ALU controls stay up from EXEC until retire so address/result remain stable.
    if (st == EXEC || st == MEM || st == WB) begin
      case (op)
        OP_ALU: c.alu_op = fn[3:0];
        OP_ALUI: begin
          c.alu_op       = fn[3:0];
          c.alu_mux_ctrl = 1'b1;
        end
        OP_LW, OP_SW: begin
          c.alu_op       = ALU_ADD;
          c.alu_mux_ctrl = 1'b1;
          c.imm_mux_ctrl = 1'b1;
        end
        default: ;
      endcase
    end
    case (st)
      FETCH: c.ir_write = 1'b1;
      EXEC: begin
        case (op)
          OP_ALU, OP_ALUI, OP_LW, OP_SW, OP_HALT: ;
          OP_BR: begin
            c.pc_write = 1'b1;
            c.br_op    = {1'b1, fn[3:0]};
          end
          OP_BL: begin
            c.pc_write           = 1'b1;
            c.br_op              = {1'b1, fn[3:0]};
            c.reg_write          = RW_LINK;
            c.reg_write_mux_ctrl = WB_LINK;
          end
          default: begin
            c.illegal_op = 1'b1;
            c.pc_write   = 1'b1;
          end
        endcase
      end
      MEM: begin
        c.dmem_enable = 1'b1;
        if (op == OP_SW) begin
          c.dmem_write_enable = 1'b1;
          c.pc_write          = mem_last;
        end
      end
      WB: begin
        c.reg_write          = RW_RS;
        c.pc_write           = 1'b1;
        c.reg_write_mux_ctrl = (op == OP_LW) ? WB_MEM : WB_ALU;
      end
      HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter timing the data-memory access; saturates at zero.
module mem_wait_counter
  import mini_risc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              done,
  output logic              done_next_c
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WAIT_W'(1);
    end
  end

  assign done_next_c = (count_d == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      done    <= 1'b1;
    end else begin
      count_q <= count_d;
      done    <= done_next_c;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP mini-RISC core.
module multicycle_control_unit
  import mini_risc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNC_W-1:0]   func,
  output logic                pc_write,
  output logic                ir_write,
  output logic [1:0]          reg_write,
  output logic                imm_mux_ctrl,
  output logic                alu_mux_ctrl,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                dmem_enable,
  output logic                dmem_write_enable,
  output logic [1:0]          reg_write_mux_ctrl,
  output logic [BR_OP_W-1:0]  br_op,
  output logic                halted,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count
);

  state_t            state_q;
  state_t            state_d;
  logic [OP_W-1:0]   op_q;
  logic [OP_W-1:0]   op_d;
  logic [FUNC_W-1:0] func_q;
  logic [FUNC_W-1:0] func_d;
  logic              primed_q;
  ctrl_t             ctrl_q;
  ctrl_t             ctrl_d;
  logic [CNT_W-1:0]  count_q;
  logic              halt_entry;
  logic              wait_load;
  logic              wait_dec;
  logic              wait_done;
  logic              wait_done_next;

  assign wait_load = (state_q == EXEC);
  assign wait_dec  = (state_q == MEM);

  mem_wait_counter u_wait (
    .clk         (clk),
    .rst         (rst),
    .load        (wait_load),
    .load_val    (WAIT_W'(MEM_LAT - 1)),
    .dec         (wait_dec),
    .done        (wait_done),
    .done_next_c (wait_done_next)
  );

  // Outputs are registered from the next state; the first edge after reset only loads FETCH's outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    func_d     = func_q;
    halt_entry = 1'b0;
    if (state_q == DECODE) begin
      op_d   = opcode;
      func_d = func;
    end
    if (!primed_q) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: state_d = EXEC;
        EXEC: begin
          case (op_q)
            OP_ALU, OP_ALUI: state_d = WB;
            OP_LW, OP_SW:    state_d = MEM;
            OP_HALT:         state_d = HALT;
            default:         state_d = FETCH;
          endcase
        end
        MEM: begin
          if (wait_done) state_d = (op_q == OP_LW) ? WB : FETCH;
        end
        WB:      state_d = FETCH;
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
    halt_entry = (state_q != HALT) && (state_d == HALT);
    ctrl_d     = ctrl_decode(state_d, op_d, func_d, wait_done_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH;
      op_q     <= '0;
      func_q   <= '0;
      primed_q <= 1'b0;
      ctrl_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      func_q   <= func_d;
      primed_q <= 1'b1;
      ctrl_q   <= ctrl_d;
      if (ctrl_q.pc_write || halt_entry) count_q <= count_q + CNT_W'(1);
    end
  end

  assign pc_write           = ctrl_q.pc_write;
  assign ir_write           = ctrl_q.ir_write;
  assign reg_write          = ctrl_q.reg_write;
  assign imm_mux_ctrl       = ctrl_q.imm_mux_ctrl;
  assign alu_mux_ctrl       = ctrl_q.alu_mux_ctrl;
  assign alu_op             = ctrl_q.alu_op;
  assign dmem_enable        = ctrl_q.dmem_enable;
  assign dmem_write_enable  = ctrl_q.dmem_write_enable;
  assign reg_write_mux_ctrl = ctrl_q.reg_write_mux_ctrl;
  assign br_op              = ctrl_q.br_op;
  assign halted             = ctrl_q.halted;
  assign illegal_op         = ctrl_q.illegal_op;
  assign instr_count        = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed table, random instruction stream vs. per-instruction trace model.
module tb_multicycle_control_unit;

  localparam int unsigned LAT0 = 3;
  localparam int unsigned LAT1 = 1;
  localparam int unsigned CW0  = 32;
  localparam int unsigned CW1  = 4;
  localparam int          NDIR = 9;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic [1:0] reg_write;
    logic       imm_mux;
    logic       alu_mux;
    logic [3:0] alu;
    logic       dmem_en;
    logic       dmem_we;
    logic [1:0] wb_sel;
    logic [4:0] br_op;
    logic       halted;
    logic       illegal;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    int unsigned cycles;
    vec_t        retire;
    string       name;
  } dir_t;

  logic clk;
  logic rst0, rst1;
  logic [5:0] op0, fn0, op1, fn1;

  logic d0_pc, d0_ir, d0_imm, d0_am, d0_den, d0_dwe, d0_h, d0_il;
  logic [1:0] d0_rw, d0_wb;
  logic [3:0] d0_alu;
  logic [4:0] d0_br;
  logic [CW0-1:0] c0;
  logic d1_pc, d1_ir, d1_imm, d1_am, d1_den, d1_dwe, d1_h, d1_il;
  logic [1:0] d1_rw, d1_wb;
  logic [3:0] d1_alu;
  logic [4:0] d1_br;
  logic [CW1-1:0] c1;
  vec_t v0, v1;

  int n_checks;
  int n_fail;
  logic [31:0] mcnt [2];
  vec_t exp_q[$];
  dir_t dir [NDIR];

  multicycle_control_unit #(.MEM_LAT(LAT0), .CNT_W(CW0)) u_dut0 (
    .clk(clk), .rst(rst0), .opcode(op0), .func(fn0),
    .pc_write(d0_pc), .ir_write(d0_ir), .reg_write(d0_rw), .imm_mux_ctrl(d0_imm),
    .alu_mux_ctrl(d0_am), .alu_op(d0_alu), .dmem_enable(d0_den), .dmem_write_enable(d0_dwe),
    .reg_write_mux_ctrl(d0_wb), .br_op(d0_br), .halted(d0_h), .illegal_op(d0_il),
    .instr_count(c0)
  );

  multicycle_control_unit #(.MEM_LAT(LAT1), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .rst(rst1), .opcode(op1), .func(fn1),
    .pc_write(d1_pc), .ir_write(d1_ir), .reg_write(d1_rw), .imm_mux_ctrl(d1_imm),
    .alu_mux_ctrl(d1_am), .alu_op(d1_alu), .dmem_enable(d1_den), .dmem_write_enable(d1_dwe),
    .reg_write_mux_ctrl(d1_wb), .br_op(d1_br), .halted(d1_h), .illegal_op(d1_il),
    .instr_count(c1)
  );

  assign v0 = {d0_pc, d0_ir, d0_rw, d0_imm, d0_am, d0_alu, d0_den, d0_dwe, d0_wb, d0_br, d0_h, d0_il};
  assign v1 = {d1_pc, d1_ir, d1_rw, d1_imm, d1_am, d1_alu, d1_den, d1_dwe, d1_wb, d1_br, d1_h, d1_il};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic pc, input logic ir, input logic [1:0] rw,
                              input logic imm, input logic am, input logic [3:0] alu,
                              input logic den, input logic dwe, input logic [1:0] wb,
                              input logic [4:0] br, input logic il);
    vec_t v;
    v = '0;
    v.pc_write = pc; v.ir_write = ir; v.reg_write = rw; v.imm_mux = imm; v.alu_mux = am;
    v.alu = alu; v.dmem_en = den; v.dmem_we = dwe; v.wb_sel = wb; v.br_op = br; v.illegal = il;
    return v;
  endfunction

  function automatic vec_t obs(input int sel);
    return (sel == 0) ? v0 : v1;
  endfunction

  function automatic logic [31:0] cnt_of(input int sel);
    return (sel == 0) ? c0 : 32'(c1);
  endfunction

  function automatic logic [31:0] exp_cnt(input int sel);
    return (sel == 0) ? mcnt[0] : (mcnt[1] % 32'(1 << CW1));
  endfunction

  task automatic drive(input int sel, input logic [5:0] op, input logic [5:0] fn);
    if (sel == 0) begin op0 = op; fn0 = fn; end
    else begin op1 = op; fn1 = fn; end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] o;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 6'(r);
    o = 6'($urandom);
    while (o <= 6'd5 || o == 6'h3F) o = 6'($urandom);
    return o;
  endfunction

  // Expected per-cycle outputs of one instruction, from FETCH to its last cycle.
  task automatic build_trace(input logic [5:0] op, input logic [5:0] fn, input int unsigned lat);
    int unsigned len;
    bit is_mem, uses_alu, legal;
    vec_t v;
    exp_q.delete();
    is_mem   = (op == 6'd2) || (op == 6'd3);
    uses_alu = (op <= 6'd3);
    legal    = (op <= 6'd5) || (op == 6'h3F);
    if (op <= 6'd1)      len = 4;
    else if (op == 6'd2) len = 4 + lat;
    else if (op == 6'd3) len = 3 + lat;
    else                 len = 3;
    for (int c = 0; c < int'(len); c++) begin
      v = '0;
      if (c == 0) v.ir_write = 1'b1;
      if (c >= 2 && uses_alu) begin
        v.alu     = is_mem ? 4'd0 : fn[3:0];
        v.alu_mux = (op != 6'd0);
        v.imm_mux = is_mem;
      end
      if (is_mem && c >= 3 && c < 3 + int'(lat)) begin
        v.dmem_en = 1'b1;
        v.dmem_we = (op == 6'd3);
      end
      if (c == 2 && !legal) v.illegal = 1'b1;
      if (c == int'(len) - 1 && op != 6'h3F) begin
        v.pc_write = 1'b1;
        if (op == 6'd4 || op == 6'd5) v.br_op = {1'b1, fn[3:0]};
        if (op == 6'd5)       v.reg_write = 2'd2;
        else if (op <= 6'd2)  v.reg_write = 2'd1;
        if (op == 6'd2)       v.wb_sel = 2'd1;
        else if (op <= 6'd1)  v.wb_sel = 2'd2;
      end
      exp_q.push_back(v);
    end
  endtask

  // Entered at the sample point of a FETCH cycle; leaves at the sample point of the next one.
  task automatic run_instr(input int sel, input logic [5:0] op, input logic [5:0] fn, input string tag,
                           output int unsigned ret_cyc, output vec_t ret_vec);
    vec_t got;
    build_trace(op, fn, (sel == 0) ? LAT0 : LAT1);
    ret_cyc = 0;
    ret_vec = '0;
    check($sformatf("%s count", tag), 64'(cnt_of(sel)), 64'(exp_cnt(sel)));
    for (int c = 0; c < exp_q.size(); c++) begin
      got = obs(sel);
      check($sformatf("%s op=%h fn=%h cyc%0d", tag, op, fn, c), 64'(got), 64'(exp_q[c]));
      if (got.pc_write && ret_cyc == 0) begin
        ret_cyc = 32'(c + 1);
        ret_vec = got;
      end
      if (c == 1) drive(sel, op, fn);
      else drive(sel, 6'($urandom), 6'($urandom));
      @(posedge clk); #1;
    end
    mcnt[sel] = mcnt[sel] + 32'd1;
  endtask

  initial begin
    int unsigned cyc;
    vec_t rv;
    vec_t hv;
    logic [5:0] rop;
    n_checks = 0; n_fail = 0;
    mcnt[0] = '0; mcnt[1] = '0;
    rst0 = 1'b0; rst1 = 1'b0;
    op0 = '0; fn0 = '0; op1 = '0; fn1 = '0;

    dir[0] = '{op: 6'h00, fn: 6'h02, cycles: 4, retire: mk(1,0,2'd1,0,0,4'd2,0,0,2'd2,5'h00,0), name: "alu"};
    dir[1] = '{op: 6'h01, fn: 6'h25, cycles: 4, retire: mk(1,0,2'd1,0,1,4'd5,0,0,2'd2,5'h00,0), name: "alui"};
    dir[2] = '{op: 6'h02, fn: 6'h3C, cycles: 7, retire: mk(1,0,2'd1,1,1,4'd0,0,0,2'd1,5'h00,0), name: "lw"};
    dir[3] = '{op: 6'h03, fn: 6'h11, cycles: 6, retire: mk(1,0,2'd0,1,1,4'd0,1,1,2'd0,5'h00,0), name: "sw"};
    dir[4] = '{op: 6'h05, fn: 6'h03, cycles: 3, retire: mk(1,0,2'd2,0,0,4'd0,0,0,2'd0,5'h13,0), name: "bl"};
    dir[5] = '{op: 6'h04, fn: 6'h1A, cycles: 3, retire: mk(1,0,2'd0,0,0,4'd0,0,0,2'd0,5'h1A,0), name: "br"};
    dir[6] = '{op: 6'h2A, fn: 6'h0F, cycles: 3, retire: mk(1,0,2'd0,0,0,4'd0,0,0,2'd0,5'h00,1), name: "ill2a"};
    dir[7] = '{op: 6'h06, fn: 6'h3F, cycles: 3, retire: mk(1,0,2'd0,0,0,4'd0,0,0,2'd0,5'h00,1), name: "ill06"};
    dir[8] = '{op: 6'h3E, fn: 6'h21, cycles: 3, retire: mk(1,0,2'd0,0,0,4'd0,0,0,2'd0,5'h00,1), name: "ill3e"};

    repeat (3) @(posedge clk);
    #1;
    check("reset vec dut0", 64'(v0), 64'd0);
    check("reset cnt dut0", 64'(c0), 64'd0);
    check("reset vec dut1", 64'(v1), 64'd0);
    check("reset cnt dut1", 64'(c1), 64'd0);

    @(negedge clk); rst0 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NDIR; i++) begin
      run_instr(0, dir[i].op, dir[i].fn, dir[i].name, cyc, rv);
      check({dir[i].name, " cycles"}, 64'(cyc), 64'(dir[i].cycles));
      check({dir[i].name, " retire"}, 64'(rv), 64'(dir[i].retire));
    end

    for (int i = 0; i < 60; i++) begin
      rop = rand_op();
      run_instr(0, rop, 6'($urandom), "rnd0", cyc, rv);
    end

    // Abort a load in its first MEM cycle.
    check("lw fetch", 64'(v0), 64'(mk(0,1,2'd0,0,0,4'd0,0,0,2'd0,5'h00,0)));
    @(posedge clk); #1;
    drive(0, 6'h02, 6'h00);
    @(posedge clk); #1;
    drive(0, 6'h3F, 6'h3F);
    @(posedge clk); #1;
    check("lw mem dmem_en", 64'(v0.dmem_en), 64'd1);
    rst0 = 1'b0;
    #1;
    check("abort vec", 64'(v0), 64'd0);
    check("abort cnt", 64'(c0), 64'd0);
    @(posedge clk); #1;
    check("abort held vec", 64'(v0), 64'd0);
    @(negedge clk); rst0 = 1'b1;
    mcnt[0] = '0;
    @(posedge clk); #1;
    run_instr(0, 6'h00, 6'h07, "post-rst alu", cyc, rv);
    run_instr(0, 6'h3F, 6'h00, "halt", cyc, rv);
    hv = '0;
    hv.halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halted vec cyc%0d", i), 64'(v0), 64'(hv));
      check($sformatf("halted cnt cyc%0d", i), 64'(c0), 64'(mcnt[0]));
      drive(0, 6'($urandom), 6'($urandom));
      @(posedge clk); #1;
    end

    // Shortest memory latency and a narrow counter that wraps.
    @(negedge clk); rst1 = 1'b1;
    @(posedge clk); #1;
    run_instr(1, 6'h02, 6'h00, "lw lat1", cyc, rv);
    check("lw lat1 cycles", 64'(cyc), 64'd5);
    run_instr(1, 6'h03, 6'h00, "sw lat1", cyc, rv);
    check("sw lat1 cycles", 64'(cyc), 64'd4);
    for (int i = 0; i < 40; i++) begin
      rop = rand_op();
      run_instr(1, rop, 6'($urandom), "rnd1", cyc, rv);
    end
    check("dut1 wrapped count", 64'(c1), 64'(42 % 16));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
